// File: rtl/pattern_scan_ctrl.sv
// Round-robin scheduler feeding four 8-bit request channels into one serial
// overlapping "1101" detector, reporting match count and positions per frame.
module pattern_scan_ctrl (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  ack,
  output logic        busy,
  output logic        res_valid,
  output logic [1:0]  res_ch,
  output logic [2:0]  res_cnt,
  output logic [7:0]  res_pos
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S0,
    S1,
    S2,
    S3
  } det_state_t;

  ctrl_state_t state;
  det_state_t  det_state;
  det_state_t  det_next;
  logic        det_match;

  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic [1:0]  last_ch;

  logic        grant_valid;
  logic [1:0]  grant_ch;
  logic [1:0]  cand;

  // Search from the farthest offset to the nearest so the channel right after
  // last_ch wins; last_ch itself is considered last.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = last_ch;
    cand        = last_ch;
    for (int i = 4; i >= 1; i--) begin
      cand = last_ch + 2'(i);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  always_comb begin
    det_next  = S0;
    det_match = 1'b0;
    if (shift_reg[7]) begin
      unique case (det_state)
        S0: det_next = S1;
        S1: det_next = S2;
        S2: det_next = S2;
        S3: begin
          det_next  = S1;
          det_match = 1'b1;
        end
        default: det_next = S0;
      endcase
    end else begin
      unique case (det_state)
        S2:      det_next = S3;
        default: det_next = S0;
      endcase
    end
  end

  // Priority pointer resets to channel 3 so that channel 0 is searched first.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      det_state <= S0;
      shift_reg <= 8'd0;
      bit_cnt   <= 3'd0;
      last_ch   <= 2'd3;
      ack       <= 4'd0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= 2'd0;
      res_cnt   <= 3'd0;
      res_pos   <= 8'd0;
    end else begin
      ack       <= 4'd0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ack       <= 4'b0001 << grant_ch;
            shift_reg <= data[{grant_ch, 3'b000} +: 8];
            res_ch    <= grant_ch;
            last_ch   <= grant_ch;
            res_cnt   <= 3'd0;
            res_pos   <= 8'd0;
            det_state <= S0;
            bit_cnt   <= 3'd7;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          det_state <= det_next;
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt - 3'd1;
          if (det_match) begin
            res_cnt          <= res_cnt + 3'd1;
            res_pos[bit_cnt] <= 1'b1;
          end
          if (bit_cnt == 3'd0) begin
            res_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl with hand-computed results.
module tb_pattern_scan_ctrl;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [2:0]  res_cnt;
  logic [7:0]  res_pos;

  int tests;
  int fails;

  pattern_scan_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_cnt   (res_cnt),
    .res_pos   (res_pos)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
    req  = r;
    data = d;
  endtask

  task automatic nextCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic waitAck(output logic [3:0] seen);
    seen = 4'd0;
    for (int n = 0; n < 20; n++) begin
      nextCycle();
      if (ack != 4'd0) begin
        seen = ack;
        break;
      end
    end
  endtask

  task automatic doReset();
    sys_rst_n = 1'b0;
    repeat (2) nextCycle();
    sys_rst_n = 1'b1;
  endtask

  // Grants one channel, then checks the report 8 cycles after the ack.
  task automatic runFrame(input int ch, input logic [7:0] frame,
                          input logic [2:0] exp_cnt, input logic [7:0] exp_pos);
    logic [31:0] d;
    logic [3:0]  seen;
    d = 32'd0;
    d[8*ch +: 8] = frame;
    applyStimulus(4'b0001 << ch, d);
    waitAck(seen);
    checkOutput("frame_ack", 32'(seen), 32'(4'b0001 << ch));
    checkOutput("frame_busy_c1", 32'(busy), 32'd1);
    applyStimulus(4'd0, d);
    repeat (7) begin
      nextCycle();
      checkOutput("frame_no_early_valid", 32'(res_valid), 32'd0);
    end
    nextCycle();
    checkOutput("frame_res_valid", 32'(res_valid), 32'd1);
    checkOutput("frame_busy_c9", 32'(busy), 32'd1);
    checkOutput("frame_res_ch", 32'(res_ch), 32'(ch));
    checkOutput("frame_res_cnt", 32'(res_cnt), 32'(exp_cnt));
    checkOutput("frame_res_pos", 32'(res_pos), 32'(exp_pos));
    nextCycle();
    checkOutput("frame_valid_drop", 32'(res_valid), 32'd0);
    checkOutput("frame_busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] ack_v [5];
    int         ack_t [5];
    int         n_ack;
    int         cyc;
    logic [3:0] seen;
    logic       saw_valid;

    tests     = 0;
    fails     = 0;
    sys_rst_n = 1'b0;
    applyStimulus(4'd0, 32'd0);

    #12;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_ch", 32'(res_ch), 32'd0);
    checkOutput("rst_cnt", 32'(res_cnt), 32'd0);
    checkOutput("rst_pos", 32'(res_pos), 32'd0);
    #10;
    sys_rst_n = 1'b1;
    nextCycle();

    runFrame(0, 8'b1101_1010, 3'd2, 8'b0001_0010);
    runFrame(2, 8'hFF,        3'd0, 8'h00);
    runFrame(1, 8'b0110_1000, 3'd1, 8'b0000_1000);

    // Round-robin with all requests held high from a fresh reset.
    doReset();
    for (int i = 0; i < 5; i++) begin
      ack_v[i] = 4'd0;
      ack_t[i] = 0;
    end
    n_ack = 0;
    cyc   = 0;
    applyStimulus(4'b1111, 32'hA5C3_0F69);
    while (cyc < 60 && n_ack < 5) begin
      nextCycle();
      cyc++;
      if (ack != 4'd0) begin
        ack_v[n_ack] = ack;
        ack_t[n_ack] = cyc;
        n_ack++;
      end
    end
    applyStimulus(4'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr_grant", 32'(ack_v[i]), 32'(4'b0001 << (i % 4)));
      if (i > 0) checkOutput("rr_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd10);
    end
    repeat (12) nextCycle();

    runFrame(0, 8'b0000_0110, 3'd0, 8'h00);
    runFrame(1, 8'b1000_0000, 3'd0, 8'h00);

    // Reset during cycle 5 of a frame that already has one match at bit 4.
    applyStimulus(4'b1000, {8'b1101_1010, 24'd0});
    waitAck(seen);
    checkOutput("midrst_ack", 32'(seen), 32'(4'b1000));
    applyStimulus(4'd0, 32'd0);
    repeat (4) nextCycle();
    checkOutput("midrst_pre_cnt", 32'(res_cnt), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack0", 32'(ack), 32'd0);
    checkOutput("midrst_busy0", 32'(busy), 32'd0);
    checkOutput("midrst_valid0", 32'(res_valid), 32'd0);
    checkOutput("midrst_ch0", 32'(res_ch), 32'd0);
    checkOutput("midrst_cnt0", 32'(res_cnt), 32'd0);
    checkOutput("midrst_pos0", 32'(res_pos), 32'd0);
    applyStimulus(4'b1010, {8'h00, 8'h00, 8'b0110_1000, 8'h00});
    saw_valid = 1'b0;
    repeat (2) begin
      nextCycle();
      if (res_valid) saw_valid = 1'b1;
    end
    #2;
    sys_rst_n = 1'b1;
    seen = 4'd0;
    for (int n = 0; n < 20; n++) begin
      nextCycle();
      if (res_valid) saw_valid = 1'b1;
      if (ack != 4'd0) begin
        seen = ack;
        break;
      end
    end
    checkOutput("midrst_no_valid", 32'(saw_valid), 32'd0);
    checkOutput("midrst_first_grant", 32'(seen), 32'(4'b0010));
    applyStimulus(4'd0, 32'd0);
    repeat (8) nextCycle();
    checkOutput("midrst_res_valid", 32'(res_valid), 32'd1);
    checkOutput("midrst_res_ch", 32'(res_ch), 32'd1);
    checkOutput("midrst_res_pos", 32'(res_pos), 32'(8'b0000_1000));
    nextCycle();

    applyStimulus(4'd0, 32'hFFFF_FFFF);
    for (int n = 0; n < 20; n++) begin
      nextCycle();
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_ack", 32'(ack), 32'd0);
      checkOutput("idle_valid", 32'(res_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Four-channel scheduler for a shared serial "1101" pattern-detector engine. Up to four requesters each present an 8-bit frame. The controller grants one requester at a time in round-robin order and captures its frame. It shifts the frame MSB-first through the embedded overlapping 1101 detector, then reports the match count and match positions to the granted channel. It sits between the per-channel frame producers and the downstream result consumer.

## Interface
- No parameters. Channel count is fixed at 4, frame width at 8 bits and the pattern at 1101.
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset; clears all state immediately.
- req  in  4  req[i] = channel i holds a valid frame; held high until ack[i] is seen.
- data  in  32  frame of channel i is data[8*i+7 : 8*i]; stable while req[i] is high.
- ack  out  4  one-hot, one-cycle pulse; frame of channel i has been captured.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle pulse; result fields are valid.
- res_ch  out  2  channel that the result belongs to.
- res_cnt  out  3  number of pattern matches in the frame (0..2).
- res_pos  out  8  bit k set = a match completed on frame bit k.

## Operation
- Controller FSM states:
  - IDLE: if any req bit is high, grant the winner, latch its frame into the shift register, latch the channel id, clear the count and position registers, reset the detector to S0, set the bit counter to 7, and go to SHIFT. If no req is high, stay in IDLE.
  - SHIFT: each cycle, feed shift bit k (k = 7 down to 0) into the detector and decrement k. After bit 0, go to REPORT.
  - REPORT: assert res_valid for this one cycle, then return to IDLE.
- Arbitration:
  - Round-robin over req. The channel after the last granted one has highest priority, then the rest in ascending order with wrap-around.
  - After reset, channel 0 has highest priority.
  - Arbitration happens only in IDLE. req changes during SHIFT or REPORT are ignored until the controller is back in IDLE.
- Detector, with states S0, S1, S2, S3:
  - Input 0 transitions: S0→S0, S1→S0, S2→S3, S3→S0.
  - Input 1 transitions: S0→S1, S1→S2, S2→S2, S3→S1 (this last one is a match).
  - Overlap is allowed: after a match the detector continues from S1.
  - The detector restarts at S0 for every frame; no state carries across frames.
- Match accounting: on a match at bit k, increment res_cnt and set res_pos[k]. The earliest possible match bit is 4, so res_pos[7:5] is always 0.
- Outputs res_ch, res_cnt and res_pos are registered. They hold their value until the next grant clears them; they are meaningful only while res_valid is high.
- Reset values: ack=0, busy=0, res_valid=0, res_ch=0, res_cnt=0, res_pos=0, FSM=IDLE, detector=S0, priority pointer at channel 0.

## Timing
- E1 is the edge at which IDLE samples req and grants.
  - Cycle 1 (after E1): ack[ch]=1, state is SHIFT.
  - Edges E2..E9 consume bits 7..0.
  - Cycle 9 (after E9): REPORT with res_valid=1.
  - Edge E10: back to IDLE.
  - E11 is the earliest next grant.
- Result latency: res_valid arrives 8 cycles after ack. Throughput is one frame per 10 cycles under continuous requests.
- Requester handshake: on seeing ack[i] at an edge, the requester must drop req[i] (or present a new frame) by the next edge. The controller does not sample req again before E11.
- busy is high from cycle 1 through cycle 9 inclusive.
- Reset asserted mid-frame: all outputs go to 0 asynchronously and the in-flight frame is discarded with no res_valid. After release, arbitration restarts from channel 0.
- If req is all zero in IDLE, there are no ack pulses and no state change.

## Test plan
- Single channel: req=4'b0001, data[7:0]=8'b1101_1010. Expect ack=4'b0001 in cycle 1, then in cycle 9 res_valid=1, res_ch=0, res_cnt=2, res_pos=8'b0001_0010.
- No-match and no-false-match:
  - Channel 2 frame 8'hFF: res_cnt=0, res_pos=0.
  - Channel 1 frame 8'b0110_1000: res_cnt=1, res_pos=8'b0000_1000.
- Round-robin: all four req held high and re-armed after each ack. Grant order must be 0,1,2,3,0. Consecutive ack pulses are exactly 10 cycles apart.
- Frame isolation: channel 0 frame 8'b0000_0110, then channel 1 frame 8'b1000_0000. Both must give res_cnt=0; a match spanning the two frames must not be counted.
- Reset mid-operation: drop sys_rst_n during cycle 5 of a frame. Outputs must go to 0 immediately and no res_valid may appear. After release with req=4'b1010, channel 1 must be granted first.
- Idle hold: req=0 for 20 cycles. busy, ack and res_valid must stay 0 throughout.
